// File: rtl/pc_sequencer_if.sv
// Handshake bundle between the pc_sequencer (master) and its fetch/datapath environment (slave).
interface pc_sequencer_if;
   logic       start;
   logic       mem_ready;
   logic [7:0] instr;
   logic [3:0] pc_addr;
   logic       zero_flag;
   logic       incPC;
   logic       loadPC;
   logic [7:0] altPC;
   logic [7:0] ir;
   logic       alu_en;
   logic       reg_we;
   logic       halted;

   modport master (
      input  start, mem_ready, instr, pc_addr, zero_flag,
      output incPC, loadPC, altPC, ir, alu_en, reg_we, halted
   );

   modport slave (
      output start, mem_ready, instr, pc_addr, zero_flag,
      input  incPC, loadPC, altPC, ir, alu_en, reg_we, halted
   );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute control sequencer driving PC strobes, ALU enable and register write.
// Define PC_SEQ_CALL_EN to add a single link register with CALL (0xD) / RET (0xE) opcodes.
module pc_sequencer (
   input  logic           clk,
   input  logic           rst,
   pc_sequencer_if.master bus
);

   typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExecute, StHalt} state_e;

   state_e     state_q, state_d;
   logic [7:0] ir_q, ir_d;
   logic [3:0] opcode;
   logic [3:0] alt_pc;
   logic       inc_pc, load_pc, alu_en, reg_we, halted;

`ifdef PC_SEQ_CALL_EN
   logic [3:0] link_q, link_d;
`else
   logic unused_pc_addr;
   assign unused_pc_addr = ^bus.pc_addr;
`endif

   assign opcode = ir_q[7:4];

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      inc_pc  = 1'b0;
      load_pc = 1'b0;
      alt_pc  = 4'h0;
      alu_en  = 1'b0;
      reg_we  = 1'b0;
      halted  = 1'b0;
`ifdef PC_SEQ_CALL_EN
      link_d  = link_q;
`endif
      if (rst) begin
         // Load zero so the external PC clears on the same edge as the sequencer.
         load_pc = 1'b1;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.start) state_d = StFetch;
            end
            StFetch: begin
               if (bus.mem_ready) begin
                  ir_d    = bus.instr;
                  state_d = StDecode;
               end
            end
            StDecode: state_d = StExecute;
            StExecute: begin
               state_d = StFetch;
               case (opcode)
                  4'h0: inc_pc = 1'b1;
                  4'hA: begin
                     load_pc = 1'b1;
                     alt_pc  = ir_q[3:0];
                  end
                  4'hB: begin
                     if (bus.zero_flag) begin
                        load_pc = 1'b1;
                        alt_pc  = ir_q[3:0];
                     end else begin
                        inc_pc = 1'b1;
                     end
                  end
                  4'hC: begin
                     if (!bus.zero_flag) begin
                        load_pc = 1'b1;
                        alt_pc  = ir_q[3:0];
                     end else begin
                        inc_pc = 1'b1;
                     end
                  end
`ifdef PC_SEQ_CALL_EN
                  4'hD: begin
                     link_d  = bus.pc_addr + 4'd1;
                     load_pc = 1'b1;
                     alt_pc  = ir_q[3:0];
                  end
                  4'hE: begin
                     load_pc = 1'b1;
                     alt_pc  = link_q;
                  end
`else
                  4'hD, 4'hE: inc_pc = 1'b1;
`endif
                  4'hF: state_d = StHalt;
                  default: begin
                     alu_en = 1'b1;
                     reg_we = 1'b1;
                     inc_pc = 1'b1;
                  end
               endcase
            end
            StHalt: halted = 1'b1;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         ir_q    <= 8'h00;
`ifdef PC_SEQ_CALL_EN
         link_q  <= 4'h0;
`endif
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
`ifdef PC_SEQ_CALL_EN
         link_q  <= link_d;
`endif
      end
   end

   assign bus.incPC  = inc_pc;
   assign bus.loadPC = load_pc;
   assign bus.altPC  = {4'h0, alt_pc};
   assign bus.ir     = ir_q;
   assign bus.alu_en = alu_en;
   assign bus.reg_we = reg_we;
   assign bus.halted = halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a small PC counter and 16-word memory surround the DUT.
module tb_pc_sequencer;

   logic       clk;
   logic       rst;
   logic [3:0] pc;
   logic [7:0] mem [16];
   int         nvec;
   int         nfail;

   pc_sequencer_if bus ();

   pc_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Environment PC counter reacting to the sequencer's strobes.
   always @(posedge clk) begin
      if (bus.loadPC)     pc <= bus.altPC[3:0];
      else if (bus.incPC) pc <= pc + 4'd1;
   end

   assign bus.pc_addr = pc;
   assign bus.instr   = mem[pc];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic outs(input string tag, input logic inc, input logic ld, input logic [7:0] alt,
                       input logic alu, input logic we, input logic hlt);
      chk({tag, ".incPC"}, {7'h0, bus.incPC}, {7'h0, inc});
      chk({tag, ".loadPC"}, {7'h0, bus.loadPC}, {7'h0, ld});
      chk({tag, ".altPC"}, bus.altPC, alt);
      chk({tag, ".alu_en"}, {7'h0, bus.alu_en}, {7'h0, alu});
      chk({tag, ".reg_we"}, {7'h0, bus.reg_we}, {7'h0, we});
      chk({tag, ".halted"}, {7'h0, bus.halted}, {7'h0, hlt});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // incPC and loadPC must never be asserted together.
   always @(negedge clk) begin
      if (nvec > 0) chk("excl", {7'h0, bus.incPC & bus.loadPC}, 8'h00);
   end

   initial begin
      nvec          = 0;
      nfail         = 0;
      pc            = 4'h5;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.mem_ready = 1'b1;
      bus.zero_flag = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      mem[0] = 8'h10;
      mem[1] = 8'h00;
      mem[2] = 8'hF0;

      // Reset: PC cleared through loadPC with altPC 0.
      #1;
      outs("rst0", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      chk("rst_pc", {4'h0, pc}, 8'h00);
      chk("rst_ir", bus.ir, 8'h00);
      rst = 1'b0;
      #1;
      outs("idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      chk("idle_ir", bus.ir, 8'h00);

      // Program 1: ALU, NOP, HALT.
      bus.start = 1'b1;
      tick();
      outs("f1", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      chk("d1_ir", bus.ir, 8'h10);
      outs("d1", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      outs("e1", 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      tick();
      outs("f2", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      outs("e2", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      chk("d3_ir", bus.ir, 8'hF0);
      tick();
      outs("e3", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      outs("halt", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      tick();
      tick();
      outs("halt_hold", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("halt_pc", {4'h0, pc}, 8'h02);

      // Reset out of HALT.
      mem[0]  = 8'hB5;
      mem[5]  = 8'hB5;
      mem[6]  = 8'hC3;
      mem[7]  = 8'hC3;
      mem[3]  = 8'h25;
      mem[4]  = 8'hAF;
      mem[15] = 8'hD9;
      mem[9]  = 8'hE0;
      rst = 1'b1;
      #1;
      outs("rst_halt", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      #1;
      chk("rh_ir", bus.ir, 8'h00);
      outs("rh_idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Program 2: JZ taken/not, JNZ not/taken.
      tick();
      tick();
      bus.zero_flag = 1'b1;
      tick();
      outs("jz_t", 1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
      tick();
      chk("jz_pc", {4'h0, pc}, 8'h05);
      tick();
      bus.zero_flag = 1'b0;
      tick();
      outs("jz_n", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      bus.zero_flag = 1'b1;
      tick();
      outs("jnz_n", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      bus.zero_flag = 1'b0;
      tick();
      outs("jnz_t", 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);

      // Fetch stall for 4 cycles.
      tick();
      chk("stall_pc", {4'h0, pc}, 8'h03);
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stall_ir", bus.ir, 8'hC3);
         outs("stall", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      end
      bus.mem_ready = 1'b1;
      tick();
      chk("unstall_ir", bus.ir, 8'h25);
      tick();
      outs("stall_e", 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

      // JMP 15, then CALL 0xD9 at pc 15.
      tick();
      tick();
      tick();
      outs("jmp", 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0);
      tick();
      chk("call_pc", {4'h0, pc}, 8'h0F);
      tick();
      tick();
`ifdef PC_SEQ_CALL_EN
      outs("call", 1'b0, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
      tick();
      chk("ret_pc", {4'h0, pc}, 8'h09);
      tick();
      tick();
      outs("ret", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
`else
      outs("call_nop", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`endif
      tick();
      chk("wrap_pc", {4'h0, pc}, 8'h00);

      // Reset in DECODE.
      tick();
      chk("dec_ir", bus.ir, 8'hB5);
      rst = 1'b1;
      #1;
      outs("rst_dec", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      rst       = 1'b0;
      bus.start = 1'b0;
      #1;
      chk("rd_ir", bus.ir, 8'h00);
      outs("rd_idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      chk("rd_hold_ir", bus.ir, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
